mux_pipe_scan: RTL

- Parametrised, registered N-channel multiplexer with active-low strobe gating and a latched channel select.
- Successor to the 4-bit 2:1 strobed mux, generalised in width and channel count.
- Adds a fixed-latency output pipeline, an auto-scan (round-robin) mode, and select-range error detection.
- Sits between parallel sample sources and a single downstream consumer that needs a valid-qualified stream.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_sel_ctrl.sv | 60 ++++++
 rtl/mux_pipe_scan.sv | 76 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the strobed, pipelined N-channel mux.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A select bus is never narrower than one bit, even for two channels.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_ctrl.sv
// Channel-select register: load versus scan priority, wrap pulse and sticky range error.
module mux_sel_ctrl
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] i_selIn,
    input  logic             i_selLoad,
    input  logic             i_mode,
    input  logic             i_strobeN,
    output logic [SEL_W-1:0] o_curSel,
    output logic             o_wrap,
    output logic             o_selErr
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] r_curSel;
    logic             r_wrap;
    logic             r_selErr;
    logic             w_inRange;
    logic             w_scanStep;

    assign w_inRange  = ({1'b0, i_selIn} < CH_COUNT);
    assign w_scanStep = (i_mode == MODE_SCAN) && !i_strobeN;

    // Scan wraps at CHANNELS-1, so out-of-range codes can never be reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_curSel <= '0;
            r_wrap   <= 1'b0;
            r_selErr <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_selLoad) begin
                if (w_inRange) begin
                    r_curSel <= i_selIn;
                end else begin
                    r_selErr <= 1'b1;
                end
            end else if (w_scanStep) begin
                if (r_curSel == LAST_SEL) begin
                    r_curSel <= '0;
                    r_wrap   <= 1'b1;
                end else begin
                    r_curSel <= r_curSel + SEL_W'(1);
                end
            end
        end
    end

    assign o_curSel = r_curSel;
    assign o_wrap   = r_wrap;
    assign o_selErr = r_selErr;

endmodule

// File: rtl/mux_pipe_scan.sv
// Registered N-channel mux with strobe gating, auto-scan and a fixed-latency output pipeline.
module mux_pipe_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2_min1(CHANNELS),
    parameter int STAGES   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    input  logic                      mode,
    input  logic                      strobe_n,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      wrap,
    output logic                      sel_err
);

    logic [SEL_W-1:0]                  w_curSel;
    logic [WIDTH-1:0]                  w_pick;
    logic [STAGES-1:0][WIDTH-1:0]      r_data;
    logic [STAGES-1:0]                 r_valid;
    logic [STAGES-1:0][SEL_W-1:0]      r_ch;

    mux_sel_ctrl #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_selCtrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_selIn   (sel_in),
        .i_selLoad (sel_load),
        .i_mode    (mode),
        .i_strobeN (strobe_n),
        .o_curSel  (w_curSel),
        .o_wrap    (wrap),
        .o_selErr  (sel_err)
    );

    always_comb begin
        w_pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_curSel == SEL_W'(k)) begin
                w_pick = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 0 samples with the select value from before this edge's update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
            r_ch    <= '0;
        end else begin
            r_data[0]  <= strobe_n ? '0 : w_pick;
            r_valid[0] <= !strobe_n;
            r_ch[0]    <= w_curSel;
            for (int s = 1; s < STAGES; s++) begin
                r_data[s]  <= r_data[s-1];
                r_valid[s] <= r_valid[s-1];
                r_ch[s]    <= r_ch[s-1];
            end
        end
    end

    assign dout       = r_data[STAGES-1];
    assign dout_valid = r_valid[STAGES-1];
    assign dout_ch    = r_ch[STAGES-1];

endmodule
